hazard_ctrl_unit: RTL and testbench
===================================

// Module: hazard_ctrl_unit
// PURPOSE
//  Pipeline hazard controller for the 8-bit core; sits beside the ID/EX/MEM/WB registers.
//  Shadows destination-register info of in-flight instructions and drives the Execute-stage forwardA/forwardB selects.
//  Stalls IF/ID on load-use hazards and runs a flush sequence when Execute reports branch_taken.
// PARAMETERS
//  REG_AW       3  register-address width (8 architectural registers)
//  FLUSH_CYCLES 2  cycles of IF/ID + ID/EX flush after a taken branch (1..3)
//  CNT_W        16 width of statistics counters (HAZARD_STATS_EN only)
// PORTS
//  clk            in  1       rising-edge clock
//  reset          in  1       asynchronous, active-high reset
//  id_valid       in  1       ID stage holds a real instruction
//  id_rs1         in  REG_AW  ID source 1
//  id_rs2         in  REG_AW  ID source 2
//  id_uses_rs2    in  1       rs2 is read (0 when ALUsrc selects immediate)
//  id_rd          in  REG_AW  ID destination
//  id_reg_write   in  1       ID instruction writes rd
//  id_mem_read    in  1       ID instruction is a load
//  branch_taken   in  1       registered branch result from Execute
//  forwardA       out 2       00 reg1, 01 write_data_wb, 10 alu_result_mem
//  forwardB       out 2       same encoding for rs2
//  stall_if_id    out 1       hold PC and IF/ID register
//  flush_if_id    out 1       clear IF/ID register
//  flush_id_ex    out 1       insert bubble into ID/EX register
//  stall_count    out CNT_W   load-use stall cycles (HAZARD_STATS_EN only)
//  flush_count    out CNT_W   taken-branch flush events (HAZARD_STATS_EN only)
// BEHAVIOUR
//  - Reset: all shadow entries invalid, forwardA/B=00, stall/flush outputs 0, FSM=RUN, counters 0.
//  - Shadow pipe ex->mem->wb holds {valid, rd, reg_write, mem_read}; advances every cycle.
//    ex entry loads ID info on advance, or a bubble when stalling/flushing.
//  - Forward selects registered, aligned with the instruction entering EX:
//    if rs==ex.rd & ex.reg_write & ex.valid -> 10; else if matches mem entry -> 01; else 00.
//    Nearest producer wins. forwardB forced 00 when id_uses_rs2=0. rd==0 never forwards.
//  - Load-use: id_valid & ex.mem_read & ex.valid & (rs1==ex.rd | (id_uses_rs2 & rs2==ex.rd))
//    -> stall_if_id=1 and flush_id_ex=1 combinationally, same cycle; exactly one bubble.
//  - FSM RUN/FLUSH:
//    RUN: branch_taken=1 -> FLUSH, counter=FLUSH_CYCLES-1, flush_if_id=flush_id_ex=1 this cycle.
//    FLUSH: both flushes held; count down; at 0 -> RUN. branch_taken ignored in FLUSH.
//    Forward selects forced 00 while either flush is asserted.
//  - Branch and load-use in the same cycle: flush wins, stall_if_id=0.
//  - Reset asserted mid-FLUSH: immediate return to RUN, all outputs 0.
// CONFIGURATION
//  HAZARD_STATS_EN defined: stall_count increments per stall cycle; flush_count per RUN->FLUSH;
//    both saturate at all-ones and clear on reset.
//  Not defined: both ports tied to 0; no counter flops synthesised.
// STRUCTURE
//  Package hazard_pkg: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; state enum RUN/FLUSH;
//    shadow-entry struct {valid, rd, reg_write, mem_read}.
//  One sub-module: hazard_fwd_cmp, combinational rs-vs-ex/mem comparator, instanced per source.
// TESTING
//  - ex: add r3 write; ID add r4,r3,r1 -> next cycle forwardA=10, forwardB=00.
//  - Entry one behind in the pipe is r2 producer; ID rs2=r2, uses_rs2=1 -> forwardB=01; with uses_rs2=0 -> 00.
//  - ex: load r5; ID uses r5 as rs1 -> one cycle stall_if_id=1, flush_id_ex=1; then forwardA=01.
//  - branch_taken pulse with FLUSH_CYCLES=2 -> flush_if_id=flush_id_ex=1 for exactly 2 cycles; second pulse during FLUSH ignored.
//  - Branch plus load-use same cycle -> stall_if_id=0, flushes=1; reset mid-FLUSH -> all outputs 0 next edge.
//  - HAZARD_STATS_EN, CNT_W=4: 20 stalls -> stall_count=15 (saturated).

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings and shadow-entry type for the hazard controller
package hazard_pkg;

   // Execute-stage operand select encodings
   localparam logic [1:0] FWD_REG = 2'b00;   // register file read
   localparam logic [1:0] FWD_WB  = 2'b01;   // write_data_wb
   localparam logic [1:0] FWD_MEM = 2'b10;   // alu_result_mem

   // Shadow rd storage is sized for the widest supported register address;
   // narrower addresses are zero-extended before comparison.
   localparam int SHADOW_RD_W = 8;

   // Flush countdown needs to hold FLUSH_CYCLES-1, at most 2
   localparam int FLUSH_CNT_W = 2;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } hz_state_t;

   typedef struct packed {
      logic                   valid;
      logic [SHADOW_RD_W-1:0] rd;
      logic                   reg_write;
      logic                   mem_read;
   } shadow_t;

endpackage

// File: rtl/hazard_fwd_cmp.sv
// rtl/hazard_fwd_cmp.sv - one source register compared against the ex and mem shadow entries
module hazard_fwd_cmp
   import hazard_pkg::*;
#(
   parameter int REG_AW = 3
)
(
   input  logic [REG_AW-1:0]      i_rs,
   input  logic                   i_rs_used,
   input  logic                   i_ex_valid,
   input  logic [SHADOW_RD_W-1:0] i_ex_rd,
   input  logic                   i_ex_reg_write,
   input  logic                   i_mem_valid,
   input  logic [SHADOW_RD_W-1:0] i_mem_rd,
   input  logic                   i_mem_reg_write,
   output logic [1:0]             o_fwd
);

   logic [SHADOW_RD_W-1:0] w_rs;

   assign w_rs = SHADOW_RD_W'(i_rs);

   // Nearest producer wins; r0 is hardwired so it is never forwarded
   always_comb begin
      o_fwd = FWD_REG;
      if (i_rs_used && (w_rs != '0)) begin
         if (i_ex_valid && i_ex_reg_write && (i_ex_rd == w_rs)) begin
            o_fwd = FWD_MEM;
         end else if (i_mem_valid && i_mem_reg_write && (i_mem_rd == w_rs)) begin
            o_fwd = FWD_WB;
         end
      end
   end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - forwarding, load-use stall and branch flush control; HAZARD_STATS_EN adds stall/flush counters
module hazard_ctrl_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW       = 3,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_uses_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_reg_write,
   input  logic              id_mem_read,
   input  logic              branch_taken,
   output logic [1:0]        forwardA,
   output logic [1:0]        forwardB,
   output logic              stall_if_id,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic [CNT_W-1:0]  stall_count,
   output logic [CNT_W-1:0]  flush_count
);

   // Countdown value loaded on branch: the entry cycle itself is the first flush cycle
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
   localparam bit                     MULTI_FLUSH = (FLUSH_CYCLES > 1);

   shadow_t                 r_ex;
   shadow_t                 r_mem;
   shadow_t                 r_wb;
   shadow_t                 w_id_entry;
   hz_state_t               r_state;
   hz_state_t               w_state_nxt;
   logic [FLUSH_CNT_W-1:0]  r_flush_cnt;
   logic [FLUSH_CNT_W-1:0]  w_flush_cnt_nxt;
   logic                    w_load_use;
   logic                    w_flush;
   logic                    w_stall;
   logic                    w_flush_id_ex;
   logic [1:0]              w_fwd_a;
   logic [1:0]              w_fwd_b;
   logic [1:0]              r_fwd_a;
   logic [1:0]              r_fwd_b;
   logic [SHADOW_RD_W-1:0]  w_rs1_x;
   logic [SHADOW_RD_W-1:0]  w_rs2_x;
   logic                    w_unused;

   assign w_rs1_x    = SHADOW_RD_W'(id_rs1);
   assign w_rs2_x    = SHADOW_RD_W'(id_rs2);
   assign w_id_entry = '{valid:     id_valid,
                         rd:        SHADOW_RD_W'(id_rd),
                         reg_write: id_reg_write,
                         mem_read:  id_mem_read};

   // The retiring wb entry and the mem entry's load flag have no consumer here
   assign w_unused = &{1'b0, r_wb, r_mem.mem_read};

   // A load in EX whose result the ID instruction reads cannot be forwarded in time
   assign w_load_use = id_valid & r_ex.valid & r_ex.mem_read &
                       ((w_rs1_x == r_ex.rd) | (id_uses_rs2 & (w_rs2_x == r_ex.rd)));

   // Flush FSM state and countdown register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= RUN;
         r_flush_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   // Flush FSM next state: a branch starts the sequence, the countdown ends it
   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      case (r_state)
         RUN: begin
            if (branch_taken && MULTI_FLUSH) begin
               w_state_nxt     = FLUSH;
               w_flush_cnt_nxt = FLUSH_LOAD;
            end
         end
         FLUSH: begin
            if (r_flush_cnt <= FLUSH_CNT_W'(1)) begin
               w_state_nxt     = RUN;
               w_flush_cnt_nxt = '0;
            end else begin
               w_flush_cnt_nxt = r_flush_cnt - FLUSH_CNT_W'(1);
            end
         end
      endcase
   end

   // Flush FSM outputs: flush overrides a coincident load-use stall
   always_comb begin
      w_flush = 1'b0;
      w_stall = 1'b0;
      if (!reset) begin
         w_flush = (r_state == FLUSH) || branch_taken;
         w_stall = w_load_use && !w_flush;
      end
      w_flush_id_ex = w_flush | w_stall;
   end

   assign stall_if_id = w_stall;
   assign flush_if_id = w_flush;
   assign flush_id_ex = w_flush_id_ex;

   hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_a (
      .i_rs            (id_rs1),
      .i_rs_used       (1'b1),
      .i_ex_valid      (r_ex.valid),
      .i_ex_rd         (r_ex.rd),
      .i_ex_reg_write  (r_ex.reg_write),
      .i_mem_valid     (r_mem.valid),
      .i_mem_rd        (r_mem.rd),
      .i_mem_reg_write (r_mem.reg_write),
      .o_fwd           (w_fwd_a)
   );

   hazard_fwd_cmp #(.REG_AW(REG_AW)) u_cmp_b (
      .i_rs            (id_rs2),
      .i_rs_used       (id_uses_rs2),
      .i_ex_valid      (r_ex.valid),
      .i_ex_rd         (r_ex.rd),
      .i_ex_reg_write  (r_ex.reg_write),
      .i_mem_valid     (r_mem.valid),
      .i_mem_rd        (r_mem.rd),
      .i_mem_reg_write (r_mem.reg_write),
      .o_fwd           (w_fwd_b)
   );

   // Shadow pipe: the ex entry takes a bubble whenever ID/EX is being cleared
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ex  <= '0;
         r_mem <= '0;
         r_wb  <= '0;
      end else begin
         r_ex  <= w_flush_id_ex ? shadow_t'('0) : w_id_entry;
         r_mem <= r_ex;
         r_wb  <= r_mem;
      end
   end

   // Forward selects travel with the instruction into EX; bubbles get register reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fwd_a <= FWD_REG;
         r_fwd_b <= FWD_REG;
      end else begin
         r_fwd_a <= w_flush_id_ex ? FWD_REG : w_fwd_a;
         r_fwd_b <= w_flush_id_ex ? FWD_REG : w_fwd_b;
      end
   end

   assign forwardA = r_fwd_a;
   assign forwardB = r_fwd_b;

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_evt_cnt;

   // Saturating counts of stall cycles and accepted branch flushes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stall_cnt     <= '0;
         r_flush_evt_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if ((r_state == RUN) && branch_taken && (r_flush_evt_cnt != '1)) begin
            r_flush_evt_cnt <= r_flush_evt_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_count = r_stall_cnt;
   assign flush_count = r_flush_evt_cnt;
`else
   assign stall_count = '0;
   assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed vector table plus randomized run against a pipeline model
module tb_hazard_ctrl_unit;

   localparam int REG_AW       = 3;
   localparam int FLUSH_CYCLES = 2;
   localparam int CNT_W        = 4;
   localparam int CNT_MAX      = (1 << CNT_W) - 1;
`ifdef HAZARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_uses_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_write;
   logic              id_mem_read;
   logic              branch_taken;
   logic [1:0]        forwardA;
   logic [1:0]        forwardB;
   logic              stall_if_id;
   logic              flush_if_id;
   logic              flush_id_ex;
   logic [CNT_W-1:0]  stall_count;
   logic [CNT_W-1:0]  flush_count;

   hazard_ctrl_unit #(
      .REG_AW       (REG_AW),
      .FLUSH_CYCLES (FLUSH_CYCLES),
      .CNT_W        (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs2  (id_uses_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .branch_taken (branch_taken),
      .forwardA     (forwardA),
      .forwardB     (forwardB),
      .stall_if_id  (stall_if_id),
      .flush_if_id  (flush_if_id),
      .flush_id_ex  (flush_id_ex),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic drive(input bit v, input int rs1, input int rs2, input bit u,
                        input int rd, input bit wr, input bit mr, input bit bt);
      id_valid     = v;
      id_rs1       = 3'(rs1);
      id_rs2       = 3'(rs2);
      id_uses_rs2  = u;
      id_rd        = 3'(rd);
      id_reg_write = wr;
      id_mem_read  = mr;
      branch_taken = bt;
   endtask

   typedef struct {
      bit v; int rs1; int rs2; bit u; int rd; bit wr; bit mr; bit bt;
      int fa; int fb; bit st; bit fif; bit fie;
   } vec_t;

   function automatic vec_t mk(input bit v, input int rs1, input int rs2, input bit u,
                               input int rd, input bit wr, input bit mr, input bit bt,
                               input int fa, input int fb, input bit st, input bit fif,
                               input bit fie);
      vec_t t;
      t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.u = u; t.rd = rd; t.wr = wr; t.mr = mr;
      t.bt = bt; t.fa = fa; t.fb = fb; t.st = st; t.fif = fif; t.fie = fie;
      return t;
   endfunction

   // Model: the two instructions ahead of ID, nearest first
   typedef struct { bit v; int rd; bit wr; bit mr; } minst_t;
   minst_t m_pipe[2];
   int     m_flush_left;
   int     m_fa, m_fb;
   int     m_stalls, m_flushes;

   task automatic model_reset();
      for (int k = 0; k < 2; k++) m_pipe[k] = '{v: 1'b0, rd: 0, wr: 1'b0, mr: 1'b0};
      m_flush_left = 0;
      m_fa = 0; m_fb = 0; m_stalls = 0; m_flushes = 0;
   endtask

   function automatic int mfwd(input int rs);
      if (rs == 0) return 0;
      for (int k = 0; k < 2; k++)
         if (m_pipe[k].v && m_pipe[k].wr && (m_pipe[k].rd == rs))
            return (k == 0) ? 2 : 1;
      return 0;
   endfunction

   vec_t vecs[25];

   initial begin
      int r_v, r_rs1, r_rs2, r_u, r_rd, r_wr, r_mr, r_bt;
      bit e_flush, e_lu, e_stall, e_fie;

      vecs[0]  = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0);
      vecs[1]  = mk(1,1,2,1,3,1,0,0, 0,0,0,0,0);
      vecs[2]  = mk(1,3,1,1,4,1,0,0, 0,0,0,0,0);
      vecs[3]  = mk(0,0,0,0,0,0,0,0, 2,0,0,0,0);
      vecs[4]  = mk(1,0,0,0,2,1,0,0, 0,0,0,0,0);
      vecs[5]  = mk(1,0,0,0,6,1,0,0, 0,0,0,0,0);
      vecs[6]  = mk(1,0,2,1,7,1,0,0, 0,0,0,0,0);
      vecs[7]  = mk(1,0,0,0,2,1,0,0, 0,1,0,0,0);
      vecs[8]  = mk(1,0,0,0,6,1,0,0, 0,0,0,0,0);
      vecs[9]  = mk(1,0,2,0,7,0,0,0, 0,0,0,0,0);
      vecs[10] = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0);
      vecs[11] = mk(1,0,0,0,0,1,0,0, 0,0,0,0,0);
      vecs[12] = mk(1,0,0,1,5,1,0,0, 0,0,0,0,0);
      vecs[13] = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0);
      vecs[14] = mk(1,0,0,0,5,1,1,0, 0,0,0,0,0);
      vecs[15] = mk(1,5,0,0,1,1,0,0, 0,0,1,0,1);
      vecs[16] = mk(1,5,0,0,1,1,0,0, 0,0,0,0,0);
      vecs[17] = mk(0,0,0,0,0,0,0,0, 1,0,0,0,0);
      vecs[18] = mk(0,0,0,0,0,0,0,1, 0,0,0,1,1);
      vecs[19] = mk(0,0,0,0,0,0,0,1, 0,0,0,1,1);
      vecs[20] = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0);
      vecs[21] = mk(1,0,0,0,5,1,1,0, 0,0,0,0,0);
      vecs[22] = mk(1,5,0,0,1,1,0,1, 0,0,0,1,1);
      vecs[23] = mk(0,0,0,0,0,0,0,0, 0,0,0,1,1);
      vecs[24] = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0);

      reset = 1'b1;
      drive(0,0,0,0,0,0,0,0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #4;
      chk("reset_fwdA", forwardA, 0);
      chk("reset_fwdB", forwardB, 0);
      chk("reset_stall", stall_if_id, 0);
      chk("reset_flush_if_id", flush_if_id, 0);
      chk("reset_flush_id_ex", flush_id_ex, 0);
      chk("reset_stall_count", stall_count, 0);
      chk("reset_flush_count", flush_count, 0);

      // Directed table
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1 drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].u, vecs[i].rd,
                  vecs[i].wr, vecs[i].mr, vecs[i].bt);
         #4;
         chk($sformatf("vec%0d_fwdA", i), forwardA, vecs[i].fa);
         chk($sformatf("vec%0d_fwdB", i), forwardB, vecs[i].fb);
         chk($sformatf("vec%0d_stall", i), stall_if_id, vecs[i].st);
         chk($sformatf("vec%0d_flush_if_id", i), flush_if_id, vecs[i].fif);
         chk($sformatf("vec%0d_flush_id_ex", i), flush_id_ex, vecs[i].fie);
      end
      chk("dir_flush_count", flush_count, STATS ? 2 : 0);
      chk("dir_stall_count", stall_count, STATS ? 1 : 0);

      // Reset asserted in the middle of a flush sequence
      @(posedge clk);
      #1 drive(0,0,0,0,0,0,0,1);
      #4 chk("rstflush_entry", flush_if_id, 1);
      @(posedge clk);
      #1 drive(0,0,0,0,0,0,0,0);
      #4 chk("rstflush_held", flush_id_ex, 1);
      #1 reset = 1'b1;
      #1;
      chk("rstflush_fif", flush_if_id, 0);
      chk("rstflush_fie", flush_id_ex, 0);
      chk("rstflush_stall", stall_if_id, 0);
      chk("rstflush_fwdA", forwardA, 0);
      chk("rstflush_fwdB", forwardB, 0);
      reset = 1'b0;
      #1 chk("rstflush_back_to_run", flush_if_id, 0);

      // Twenty load-use stalls to exercise counter saturation
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1 drive(1,0,0,0,5,1,1,0);
         @(posedge clk);
         #1 drive(1,5,0,0,1,1,0,0);
         #4 chk($sformatf("sat_stall%0d", i), stall_if_id, 1);
      end
      @(posedge clk);
      #1 drive(0,0,0,0,0,0,0,0);
      #4;
      chk("sat_stall_count", stall_count, STATS ? 15 : 0);
      chk("sat_flush_count", flush_count, 0);

      // Randomized run against the model
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      model_reset();
      for (int n = 0; n < 400; n++) begin
         if (n != 0) begin
            @(posedge clk);
            #1;
         end
         r_v   = ($urandom_range(0, 4) != 0);
         r_rs1 = $urandom_range(0, 7);
         r_rs2 = $urandom_range(0, 7);
         r_u   = $urandom_range(0, 1);
         r_rd  = $urandom_range(0, 7);
         r_wr  = ($urandom_range(0, 3) != 0);
         r_mr  = ($urandom_range(0, 2) == 0);
         r_bt  = ($urandom_range(0, 9) == 0);
         drive(1'(r_v), r_rs1, r_rs2, 1'(r_u), r_rd, 1'(r_wr), 1'(r_mr), 1'(r_bt));
         #4;
         e_flush = (m_flush_left > 0) || (r_bt != 0);
         e_lu    = (r_v != 0) && m_pipe[0].v && m_pipe[0].mr &&
                   ((r_rs1 == m_pipe[0].rd) || ((r_u != 0) && (r_rs2 == m_pipe[0].rd)));
         e_stall = e_lu && !e_flush;
         e_fie   = e_flush || e_stall;
         chk("rnd_fwdA", forwardA, m_fa);
         chk("rnd_fwdB", forwardB, m_fb);
         chk("rnd_stall", stall_if_id, e_stall);
         chk("rnd_flush_if_id", flush_if_id, e_flush);
         chk("rnd_flush_id_ex", flush_id_ex, e_fie);
         chk("rnd_stall_count", stall_count, STATS ? m_stalls : 0);
         chk("rnd_flush_count", flush_count, STATS ? m_flushes : 0);
         // advance the model to the upcoming edge
         m_fa = e_fie ? 0 : mfwd(r_rs1);
         m_fb = (e_fie || (r_u == 0)) ? 0 : mfwd(r_rs2);
         m_pipe[1] = m_pipe[0];
         if (e_fie) m_pipe[0] = '{v: 1'b0, rd: 0, wr: 1'b0, mr: 1'b0};
         else       m_pipe[0] = '{v: 1'(r_v), rd: r_rd, wr: 1'(r_wr), mr: 1'(r_mr)};
         if (m_flush_left > 0) begin
            m_flush_left--;
         end else if (r_bt != 0) begin
            m_flush_left = FLUSH_CYCLES - 1;
            if (m_flushes < CNT_MAX) m_flushes++;
         end
         if (e_stall && (m_stalls < CNT_MAX)) m_stalls++;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
